// File: rtl/pulse_stretcher_pkg.sv
// rtl/pulse_stretcher_pkg.sv - shared state encodings and drop counter helpers
package pulse_stretcher_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACTIVE = 2'b01;
  localparam logic [1:0] ST_GUARD  = 2'b10;

  localparam int              DROP_W   = 8;
  localparam logic [DROP_W-1:0] DROP_SAT = {DROP_W{1'b1}};

  // Clear beats a simultaneous drop; the count never wraps past saturation.
  function automatic logic [DROP_W-1:0] drop_next(input logic [DROP_W-1:0] cur,
                                                  input logic              clr,
                                                  input logic              drop);
    logic [DROP_W-1:0] nxt;
    nxt = cur;
    if (clr)
      nxt = '0;
    else if (drop && cur != DROP_SAT)
      nxt = cur + 1'b1;
    return nxt;
  endfunction

endpackage

// File: rtl/pulse_stretcher_d_ff.sv
// rtl/pulse_stretcher_d_ff.sv - generic register with asynchronous active-high reset to zero
module pulse_stretcher_d_ff #(
  parameter int D_SIZE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [D_SIZE-1:0] d,
  output logic [D_SIZE-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      q <= '0;
    else
      q <= d;
  end

endmodule

// File: rtl/pulse_stretcher.sv
// rtl/pulse_stretcher.sv - stretches an enable edge into a C_MAX-cycle level with optional hold-off
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int C_SIZE = 4,
  parameter int C_MAX  = 10,
  parameter int G_MAX  = 0,
  parameter int RETRIG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              clr_drop,
  output logic              en_s,
  output logic              busy,
  output logic              done,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [C_SIZE-1:0] C_LAST = C_SIZE'(C_MAX - 1);
  localparam logic [C_SIZE-1:0] G_LAST = (G_MAX > 0) ? C_SIZE'(G_MAX - 1) : '0;

  logic              r_en_q;
  logic [1:0]        r_state;
  logic [C_SIZE-1:0] r_cnt;
  logic [2:0]        r_flags;
  logic [DROP_W-1:0] r_drop;

  logic              w_event;
  logic              w_drop;
  logic [1:0]        w_state_nxt;
  logic [C_SIZE-1:0] w_cnt_nxt;
  logic              w_en_s_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic [DROP_W-1:0] w_drop_nxt;

  assign w_event = en & ~r_en_q;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_en_s_nxt  = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (w_event) begin
          w_state_nxt = ST_ACTIVE;
          w_en_s_nxt  = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      ST_ACTIVE: begin
        w_cnt_nxt  = r_cnt + 1'b1;
        w_en_s_nxt = 1'b1;
        w_busy_nxt = 1'b1;
        // A retrigger outranks termination, even on the last active cycle.
        if (w_event && RETRIG != 0) begin
          w_cnt_nxt = '0;
        end else begin
          w_drop = w_event;
          if (r_cnt == C_LAST) begin
            w_cnt_nxt  = '0;
            w_en_s_nxt = 1'b0;
            w_done_nxt = 1'b1;
            if (G_MAX > 0) begin
              w_state_nxt = ST_GUARD;
            end else begin
              w_state_nxt = ST_IDLE;
              w_busy_nxt  = 1'b0;
            end
          end
        end
      end
      ST_GUARD: begin
        w_cnt_nxt  = r_cnt + 1'b1;
        w_busy_nxt = 1'b1;
        w_drop     = w_event;
        if (r_cnt == G_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_drop_nxt = drop_next(r_drop, clr_drop, w_drop);

  pulse_stretcher_d_ff #(.D_SIZE(1)) u_en_q (
    .clk(clk), .reset(reset), .d(en), .q(r_en_q)
  );

  pulse_stretcher_d_ff #(.D_SIZE(2)) u_state (
    .clk(clk), .reset(reset), .d(w_state_nxt), .q(r_state)
  );

  pulse_stretcher_d_ff #(.D_SIZE(C_SIZE)) u_cnt (
    .clk(clk), .reset(reset), .d(w_cnt_nxt), .q(r_cnt)
  );

  pulse_stretcher_d_ff #(.D_SIZE(3)) u_flags (
    .clk(clk), .reset(reset), .d({w_en_s_nxt, w_busy_nxt, w_done_nxt}), .q(r_flags)
  );

  pulse_stretcher_d_ff #(.D_SIZE(DROP_W)) u_drop (
    .clk(clk), .reset(reset), .d(w_drop_nxt), .q(r_drop)
  );

  assign en_s     = r_flags[2];
  assign busy     = r_flags[1];
  assign done     = r_flags[0];
  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb/tb_pulse_stretcher.sv - scoreboard bench driving three parameterisations with shared stimulus
module tb_pulse_stretcher;

  localparam int CM   = 10;
  localparam int NONE = -1000000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic clr_drop = 1'b0;

  always #5 clk = ~clk;

  logic       en_s0, busy0, done0, en_s1, busy1, done1, en_s2, busy2, done2;
  logic [7:0] drop0, drop1, drop2;

  pulse_stretcher #(.C_SIZE(4), .C_MAX(CM), .G_MAX(4), .RETRIG(0)) dut_g4 (
    .clk(clk), .reset(reset), .en(en), .clr_drop(clr_drop),
    .en_s(en_s0), .busy(busy0), .done(done0), .drop_cnt(drop0)
  );

  pulse_stretcher #(.C_SIZE(4), .C_MAX(CM), .G_MAX(4), .RETRIG(1)) dut_rt (
    .clk(clk), .reset(reset), .en(en), .clr_drop(clr_drop),
    .en_s(en_s1), .busy(busy1), .done(done1), .drop_cnt(drop1)
  );

  pulse_stretcher #(.C_SIZE(4), .C_MAX(CM), .G_MAX(0), .RETRIG(0)) dut_g0 (
    .clk(clk), .reset(reset), .en(en), .clr_drop(clr_drop),
    .en_s(en_s2), .busy(busy2), .done(done2), .drop_cnt(drop2)
  );

  logic [10:0] act [3];
  assign act[0] = {en_s0, busy0, done0, drop0};
  assign act[1] = {en_s1, busy1, done1, drop1};
  assign act[2] = {en_s2, busy2, done2, drop2};

  int gmax   [3] = '{4, 4, 0};
  int retrig [3] = '{0, 1, 0};

  // Model: each pulse is described only by the edge index at which it was accepted.
  int         m_t;
  int         m_start [3];
  logic [7:0] m_drop  [3];
  logic       m_enq;

  logic [32:0] exp_q [$];
  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic model_step(input logic e_in, input logic clr, input logic rst,
                            output logic [32:0] exp_o);
    logic ev;
    int   d;
    logic dropped;
    logic o_en, o_busy, o_done;
    exp_o = '0;
    m_t++;
    if (rst) begin
      m_enq = 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_start[i] = NONE;
        m_drop[i]  = 8'd0;
      end
      return;
    end
    ev    = e_in & ~m_enq;
    m_enq = e_in;
    for (int i = 0; i < 3; i++) begin
      dropped = 1'b0;
      d = m_t - m_start[i];
      if (ev) begin
        if (d >= 1 && d <= CM) begin
          if (retrig[i] != 0) m_start[i] = m_t;
          else dropped = 1'b1;
        end else if (d > CM && d <= CM + gmax[i]) begin
          dropped = 1'b1;
        end else begin
          m_start[i] = m_t;
        end
      end
      if (clr) m_drop[i] = 8'd0;
      else if (dropped && m_drop[i] != 8'd255) m_drop[i] = m_drop[i] + 8'd1;
      d      = m_t - m_start[i];
      o_en   = (d >= 0 && d <= CM - 1);
      o_done = (d == CM);
      o_busy = (d >= 0 && d <= CM + gmax[i] - 1);
      exp_o[i*11 +: 11] = {o_en, o_busy, o_done, m_drop[i]};
    end
  endtask

  task automatic drive(input logic e_in, input logic clr, input logic rst);
    logic [32:0] e;
    @(negedge clk);
    en       = e_in;
    clr_drop = clr;
    reset    = rst;
    model_step(e_in, clr, rst, e);
    exp_q.push_back(e);
  endtask

  task automatic check_async_zero();
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (act[i] !== 11'd0) begin
        n_fail++;
        $display("FAIL async_reset dut%0d got=%h want=000", i, act[i]);
      end
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
          n_vec++;
          if (act[i] !== e[i*11 +: 11]) begin
            n_fail++;
            $display("FAIL outputs dut%0d cycle %0d got en_s=%b busy=%b done=%b drop=%0d want en_s=%b busy=%b done=%b drop=%0d",
                     i, cyc, act[i][10], act[i][9], act[i][8], act[i][7:0],
                     e[i*11+10], e[i*11+9], e[i*11+8], e[i*11 +: 8]);
          end
        end
      end
    end
  end

  initial begin : driver
    int wait_cyc;
    m_t   = 0;
    m_enq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_start[i] = NONE;
      m_drop[i]  = 8'd0;
    end

    for (int j = 0; j < 3; j++) drive(1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 4; j++) drive(1'b0, 1'b0, 1'b0);
    // Single pulse, then drops in active and guard, then a late retrigger.
    for (int j = 0; j < 25; j++) drive(j == 0, 1'b0, 1'b0);
    for (int j = 0; j < 25; j++) drive(j == 0 || j == 3 || j == 12, 1'b0, 1'b0);
    for (int j = 0; j < 30; j++) drive(j == 0 || j == 9, 1'b0, 1'b0);
    // Held level, then an event on the first cycle after busy falls.
    for (int j = 0; j < 50; j++) drive(1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 10; j++) drive(1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 35; j++) drive(j == 0 || j == 15, 1'b0, 1'b0);
    for (int j = 0; j < 70; j++) drive(j < 55 && (j % 11) == 0, 1'b0, 1'b0);
    // Drop saturation, then clear coinciding with a dropped event.
    for (int j = 0; j < 800; j++) drive((j % 2) == 0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    for (int j = 0; j < 20; j++) drive(1'b0, 1'b0, 1'b0);
    // Reset mid-pulse, released with en held high.
    drive(1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    #1;
    check_async_zero();
    drive(1'b1, 1'b0, 1'b1);
    for (int j = 0; j < 20; j++) drive(1'b1, 1'b0, 1'b0);
    for (int j = 0; j < 600; j++)
      drive($urandom_range(0, 4) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 150) == 0);
    drive(1'b0, 1'b0, 1'b0);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
